// File: rtl/gin_pkg.sv
// Shared types and helpers for the GIN multicast X-bus.
// Tag comparisons take 32-bit operands so every tag width can use one helper.
package gin_pkg;

    localparam int GIN_COL_TAG_WIDTH_DEF = 4;
    localparam int GIN_FIFO_DEPTH_DEF    = 4;
    localparam int GIN_TAG_MAX_W         = 32;

    typedef logic [GIN_COL_TAG_WIDTH_DEF-1:0] col_tag_t;

    // Inclusive unsigned range test. An inverted range (lo > hi) matches nothing.
    function automatic logic tag_in_range(
        input logic [GIN_TAG_MAX_W-1:0] lo,
        input logic [GIN_TAG_MAX_W-1:0] hi,
        input logic [GIN_TAG_MAX_W-1:0] id
    );
        return (lo <= id) && (id <= hi);
    endfunction

endpackage

// File: rtl/gin_col_ctrl.sv
// One X-bus column: scan-loaded ID register, tag-range match and a small FIFO.
// The head word reads as zero while the FIFO is empty.
module gin_col_ctrl
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int COL_TAG_WIDTH = GIN_COL_TAG_WIDTH_DEF,
    parameter int FIFO_DEPTH    = GIN_FIFO_DEPTH_DEF
) (
    input  logic                     link_clk,
    input  logic                     reset,
    input  logic                     i_se_id,
    input  logic                     i_scan_in,
    output logic                     o_scan_out,
    input  logic [COL_TAG_WIDTH-1:0] i_tag_lo,
    input  logic [COL_TAG_WIDTH-1:0] i_tag_hi,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_push,
    input  logic                     i_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_valid,
    output logic                     o_match,
    output logic                     o_full
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [COL_TAG_WIDTH-1:0] r_id;
    logic [DATA_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;

    logic w_empty;
    logic w_full;
    logic w_wr;
    logic w_rd;

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            r_id <= '0;
        end else if (i_se_id) begin
            r_id <= {i_scan_in, r_id[COL_TAG_WIDTH-1:1]};
        end
    end

    assign o_scan_out = r_id[0];
    assign o_match    = tag_in_range(GIN_TAG_MAX_W'(i_tag_lo), GIN_TAG_MAX_W'(i_tag_hi),
                                     GIN_TAG_MAX_W'(r_id));

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    // Full is taken before this cycle's pop, so a full FIFO never passes a word through.
    assign w_wr    = i_push && !w_full;
    assign w_rd    = i_ready && !w_empty;

    always_ff @(posedge link_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;

endmodule

// File: rtl/gin_xbus_mc.sv
// Multicast X-bus for one GIN row: one word per clock goes to every column whose
// scanned ID lies in [tag_lo, tag_hi]; each column buffers independently.
module gin_xbus_mc
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int COL_TAG_WIDTH = GIN_COL_TAG_WIDTH_DEF,
    parameter int NUM_OF_COLS   = 14,
    parameter int FIFO_DEPTH    = GIN_FIFO_DEPTH_DEF
) (
    input  logic                     link_clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [COL_TAG_WIDTH-1:0] tag_lo,
    input  logic [COL_TAG_WIDTH-1:0] tag_hi,
    input  logic                     enable_in,
    output logic                     ready_out,
    output logic [DATA_WIDTH-1:0]    data_out [0:NUM_OF_COLS-1],
    output logic [NUM_OF_COLS-1:0]   enable_out,
    input  logic [NUM_OF_COLS-1:0]   ready_in,
    input  logic                     se_id,
    input  logic                     si_id,
    output logic                     so_id,
    output logic                     miss_err
);

    logic [NUM_OF_COLS-1:0] w_match;
    logic [NUM_OF_COLS-1:0] w_full;
    logic [NUM_OF_COLS-1:0] w_push;
    logic [NUM_OF_COLS:0]   w_chain;
    logic                   w_accept;
    logic                   r_miss_err;

    assign w_chain[0] = si_id;
    assign so_id      = w_chain[NUM_OF_COLS];

    for (genvar g = 0; g < NUM_OF_COLS; g++) begin : g_col
        gin_col_ctrl #(
            .DATA_WIDTH    (DATA_WIDTH),
            .COL_TAG_WIDTH (COL_TAG_WIDTH),
            .FIFO_DEPTH    (FIFO_DEPTH)
        ) u_col (
            .link_clk   (link_clk),
            .reset      (reset),
            .i_se_id    (se_id),
            .i_scan_in  (w_chain[g]),
            .o_scan_out (w_chain[g+1]),
            .i_tag_lo   (tag_lo),
            .i_tag_hi   (tag_hi),
            .i_data     (data_in),
            .i_push     (w_push[g]),
            .i_ready    (ready_in[g]),
            .o_data     (data_out[g]),
            .o_valid    (enable_out[g]),
            .o_match    (w_match[g]),
            .o_full     (w_full[g])
        );
    end

    // All-or-none multicast: any matching full column holds the whole bus.
    assign ready_out = !se_id && !(|(w_match & w_full));
    assign w_accept  = enable_in && ready_out;
    assign w_push    = {NUM_OF_COLS{w_accept}} & w_match;

    always_ff @(posedge link_clk or negedge reset) begin
        if (!reset) begin
            r_miss_err <= 1'b0;
        end else if (w_accept && !(|w_match)) begin
            r_miss_err <= 1'b1;
        end
    end

    assign miss_err = r_miss_err;

endmodule

// File: tb/tb_gin_xbus_mc.sv
// Directed bench for gin_xbus_mc: stimulus pushes expected words per column,
// a monitor pops and compares whenever a column hands off its head word.
module tb_gin_xbus_mc;
    import gin_pkg::*;

    localparam int DW = 64;
    localparam int TW = 4;
    localparam int NC = 14;
    localparam int FD = 4;

    logic          link_clk = 1'b0;
    logic          reset    = 1'b0;
    logic [DW-1:0] data_in  = '0;
    col_tag_t      tag_lo   = '0;
    col_tag_t      tag_hi   = '0;
    logic          enable_in = 1'b0;
    logic          ready_out;
    logic [DW-1:0] data_out [0:NC-1];
    logic [NC-1:0] enable_out;
    logic [NC-1:0] ready_in = '0;
    logic          se_id = 1'b0;
    logic          si_id = 1'b0;
    logic          so_id;
    logic          miss_err;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [NC][$];

    gin_xbus_mc #(
        .DATA_WIDTH    (DW),
        .COL_TAG_WIDTH (TW),
        .NUM_OF_COLS   (NC),
        .FIFO_DEPTH    (FD)
    ) dut (
        .link_clk   (link_clk),
        .reset      (reset),
        .data_in    (data_in),
        .tag_lo     (tag_lo),
        .tag_hi     (tag_hi),
        .enable_in  (enable_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .enable_out (enable_out),
        .ready_in   (ready_in),
        .se_id      (se_id),
        .si_id      (si_id),
        .so_id      (so_id),
        .miss_err   (miss_err)
    );

    always #5 link_clk = ~link_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid && ready.
    initial begin
        forever begin
            @(negedge link_clk);
            if (reset) begin
                for (int i = 0; i < NC; i++) begin
                    if (enable_out[i] && ready_in[i]) begin
                        if (exp_q[i].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL col_unexpected: col %0d got %h expected no word", i, data_out[i]);
                        end else begin
                            chk($sformatf("col%0d_data", i), data_out[i], exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] lo, input logic [TW-1:0] hi,
                        input logic [NC-1:0] mask, input int budget, output bit ok);
        data_in   = d;
        tag_lo    = lo;
        tag_hi    = hi;
        enable_in = 1'b1;
        ok        = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge link_clk);
            if (ready_out) begin
                ok = 1'b1;
                for (int i = 0; i < NC; i++) begin
                    if (mask[i]) exp_q[i].push_back(d);
                end
            end
        end
        @(posedge link_clk);
        #1;
        enable_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge link_clk);
            done = (enable_out == '0);
            for (int i = 0; i < NC; i++) begin
                if (exp_q[i].size() != 0) done = 1'b0;
            end
        end
        chk(name, 64'(done), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit stream[$];
        logic [TW-1:0] idv;

        // Reset state, sampled before any clock edge.
        #1;
        chk("rst_enable_out", 64'(enable_out), 64'(0));
        chk("rst_so_id", 64'(so_id), 64'(0));
        chk("rst_miss_err", 64'(miss_err), 64'(0));
        chk("rst_data_out0", data_out[0], 64'(0));
        #20;
        reset = 1'b1;
        @(posedge link_clk);
        #1;

        // Scan ID k into column k: the last column's bits go first, LSB first.
        for (int c = NC - 1; c >= 0; c--) begin
            idv = TW'(c);
            for (int b = 0; b < TW; b++) stream.push_back(idv[b]);
        end
        se_id = 1'b1;
        for (int k = 0; k < NC * TW; k++) begin
            si_id = stream[k];
            @(negedge link_clk);
            chk("scan_ready_low", 64'(ready_out), 64'(0));
            if (k == NC * TW - 1) chk("scan_so_before_full", 64'(so_id), 64'(0));
            @(posedge link_clk);
            #1;
        end
        se_id = 1'b0;
        si_id = 1'b0;
        chk("scan_so_first_bit", 64'(so_id), 64'(stream[0]));
        @(negedge link_clk);
        chk("scan_ready_after", 64'(ready_out), 64'(1));
        @(posedge link_clk);
        #1;

        // Single-column delivery, one cycle latency.
        ready_in = '1;
        send(64'hA5A5_0000_0000_0001, 4'd5, 4'd5, 14'h0020, 20, ok);
        chk("t2_accept", 64'(ok), 64'(1));
        chk("t2_enable_out", 64'(enable_out), 64'(14'h0020));
        chk("t2_data5", data_out[5], 64'hA5A5_0000_0000_0001);
        @(posedge link_clk);
        #1;
        chk("t2_enable_after_pop", 64'(enable_out), 64'(0));

        // Range 2..9 with those columns stalled: four words fill them.
        ready_in = ~14'h03FC;
        for (int w = 0; w < 4; w++) begin
            send(64'h3300_0000_0000_0000 + 64'(w), 4'd2, 4'd9, 14'h03FC, 20, ok);
            chk("t3_accept", 64'(ok), 64'(1));
        end
        send(64'h3300_0000_0000_0004, 4'd2, 4'd9, 14'h03FC, 5, ok);
        chk("t3_stall", 64'(ok), 64'(0));
        chk("t3_ready_low", 64'(ready_out), 64'(0));
        chk("t3_enable_out", 64'(enable_out), 64'(14'h03FC));
        ready_in = '1;
        @(negedge link_clk);
        chk("t3_ready_before_pop", 64'(ready_out), 64'(0));
        @(negedge link_clk);
        chk("t3_ready_after_pop", 64'(ready_out), 64'(1));
        @(posedge link_clk);
        #1;
        for (int w = 4; w < 8; w++) begin
            send(64'h3300_0000_0000_0000 + 64'(w), 4'd2, 4'd9, 14'h03FC, 20, ok);
            chk("t3_accept_tail", 64'(ok), 64'(1));
        end
        wait_drain("t3_drain");

        // Broadcast with column 7 stalled.
        @(posedge link_clk);
        #1;
        ready_in = ~14'h0080;
        for (int w = 0; w < 4; w++) begin
            send(64'h4400_0000_0000_0010 + 64'(w), 4'd0, 4'd15, 14'h3FFF, 20, ok);
            chk("t4_accept", 64'(ok), 64'(1));
        end
        send(64'h4400_0000_0000_0014, 4'd0, 4'd15, 14'h3FFF, 5, ok);
        chk("t4_stall", 64'(ok), 64'(0));
        chk("t4_only_col7", 64'(enable_out), 64'(14'h0080));
        chk("t4_col7_head", data_out[7], 64'h4400_0000_0000_0010);
        ready_in = '1;
        wait_drain("t4_drain");

        // Inverted range: word dropped, sticky miss flag.
        chk("t5_miss_before", 64'(miss_err), 64'(0));
        @(posedge link_clk);
        #1;
        data_in   = 64'h5555_0000_0000_0000;
        tag_lo    = 4'd12;
        tag_hi    = 4'd3;
        enable_in = 1'b1;
        @(negedge link_clk);
        chk("t5_ready", 64'(ready_out), 64'(1));
        @(posedge link_clk);
        #1;
        enable_in = 1'b0;
        chk("t5_miss_set", 64'(miss_err), 64'(1));
        chk("t5_no_enable", 64'(enable_out), 64'(0));
        send(64'h5555_0000_0000_0003, 4'd3, 4'd3, 14'h0008, 20, ok);
        chk("t5_accept_after", 64'(ok), 64'(1));
        wait_drain("t5_drain");
        chk("t5_miss_sticky", 64'(miss_err), 64'(1));

        // Asynchronous reset with three words buffered in column 0.
        @(posedge link_clk);
        #1;
        ready_in = '0;
        for (int w = 0; w < 3; w++) begin
            send(64'h6600_0000_0000_0000 + 64'(w), 4'd0, 4'd0, 14'h0001, 20, ok);
            chk("t6_accept", 64'(ok), 64'(1));
        end
        chk("t6_enable_before", 64'(enable_out), 64'(14'h0001));
        chk("t6_so_before", 64'(so_id), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("t6_enable_rst", 64'(enable_out), 64'(0));
        chk("t6_miss_rst", 64'(miss_err), 64'(0));
        chk("t6_so_rst", 64'(so_id), 64'(0));
        chk("t6_data0_rst", data_out[0], 64'(0));
        for (int i = 0; i < NC; i++) exp_q[i].delete();
        @(negedge link_clk);
        reset = 1'b1;
        @(posedge link_clk);
        #1;

        // IDs were lost: every column now carries ID 0.
        ready_in = '1;
        send(64'h7700_0000_0000_0000, 4'd0, 4'd0, 14'h3FFF, 20, ok);
        chk("t7_accept", 64'(ok), 64'(1));
        chk("t7_all_cols", 64'(enable_out), 64'(14'h3FFF));
        wait_drain("t7_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
